// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared encodings and trap cause codes for pipeline_ctrl
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRAP   = 2'd1;
  localparam logic [1:0] ST_VECTOR = 2'd2;

  localparam logic [31:0] IRQ_CAUSE_DEFAULT = 32'h8000_000B;

  localparam logic [4:0] EXC_ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0] EXC_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] EXC_STORE_MISALIGNED = 5'd6;
  localparam logic [4:0] EXC_ECALL_M          = 5'd11;

  function automatic logic [31:0] exc_mcause(input logic [4:0] code);
    return {27'b0, code};
  endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/redirect merge and trap entry sequencer for the RV32I pipeline
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] IRQ_CAUSE = IRQ_CAUSE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        jump_req_ex,
  input  logic [31:0] jump_addr,
  input  logic        mret_req_ex,
  input  logic        exc_req_mem,
  input  logic [4:0]  exc_cause,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        irq_pending,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        hold_flag_if,
  output logic        hold_flag_id,
  output logic        hold_flag_ex,
  output logic        hold_flag_mem,
  output logic        hold_flag_wb,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        flush_mem,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        csr_trap_we,
  output logic [31:0] csr_mepc,
  output logic [31:0] csr_mcause,
  output logic        csr_mret_we,
  output logic [1:0]  ctrl_state
);

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] mepc_q;
  logic [31:0] cause_q;
  logic        trap_take;
  logic [31:0] trap_cause;

  always_comb begin
    state_d        = ST_IDLE;
    trap_take      = 1'b0;
    trap_cause     = 32'd0;
    hold_flag_if   = 1'b0;
    hold_flag_id   = 1'b0;
    hold_flag_ex   = 1'b0;
    hold_flag_mem  = 1'b0;
    hold_flag_wb   = 1'b0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    flush_mem      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    csr_trap_we    = 1'b0;
    csr_mepc       = 32'd0;
    csr_mcause     = 32'd0;
    csr_mret_we    = 1'b0;

    case (state_q)
      ST_TRAP: begin
        csr_trap_we  = 1'b1;
        csr_mepc     = mepc_q;
        csr_mcause   = cause_q;
        hold_flag_if = 1'b1;
        flush_id     = 1'b1;
        flush_ex     = 1'b1;
        state_d      = ST_VECTOR;
      end
      ST_VECTOR: begin
        redirect_valid = 1'b1;
        redirect_pc    = mtvec & ~32'h3;
        flush_id       = 1'b1;
        flush_ex       = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        // A MEM-side bus wait freezes every request so it re-presents after the stall.
        if (!stall_req_mem && (exc_req_mem || (irq_pending && mem_valid))) begin
          trap_take  = 1'b1;
          trap_cause = exc_req_mem ? exc_mcause(exc_cause) : IRQ_CAUSE;
          flush_if   = 1'b1;
          flush_id   = 1'b1;
          flush_ex   = 1'b1;
          flush_mem  = 1'b1;
          state_d    = ST_TRAP;
        end else if (mret_req_ex && !stall_req_mem) begin
          flush_if       = 1'b1;
          flush_id       = 1'b1;
          csr_mret_we    = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = mepc;
        end else if (jump_req_ex && !stall_req_mem) begin
          flush_if       = 1'b1;
          flush_id       = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = jump_addr;
        end else begin
          hold_flag_if  = stall_req_id | stall_req_ex | stall_req_mem;
          hold_flag_id  = stall_req_id | stall_req_ex | stall_req_mem;
          hold_flag_ex  = stall_req_ex | stall_req_mem;
          hold_flag_mem = stall_req_mem;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mepc_q  <= 32'd0;
      cause_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (trap_take) begin
        mepc_q  <= mem_pc;
        cause_q <= trap_cause;
      end
    end
  end

  assign ctrl_state = state_q;

endmodule
